// File: rtl/jstk_pkg.sv
// jstk_pkg: shared encodings, PmodJSTK frame field positions and default thresholds.
package jstk_pkg;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;
  typedef enum logic [1:0] {Z_NONE = 2'd0, Z_POS = 2'd1, Z_NEG = 2'd2} zone_t;
  localparam int X_LO_LSB = 32;
  localparam int X_HI_LSB = 24;
  localparam int Y_LO_LSB = 16;
  localparam int Y_HI_LSB = 8;
  localparam int BTN_W    = 3;
  localparam logic [9:0] DEF_DEAD_LO = 10'd384;
  localparam logic [9:0] DEF_DEAD_HI = 10'd640;
  localparam logic [9:0] DEF_HYST    = 10'd32;
  function automatic logic [9:0] get_x(input logic [39:0] d);
    return {d[X_HI_LSB+:2], d[X_LO_LSB+:8]};
  endfunction
  function automatic logic [9:0] get_y(input logic [39:0] d);
    return {d[Y_HI_LSB+:2], d[Y_LO_LSB+:8]};
  endfunction
endpackage

// File: rtl/jstk_axis_zone.sv
// jstk_axis_zone: per-axis deflection zone with hysteresis, updated on each frame strobe.
module jstk_axis_zone
  import jstk_pkg::*;
#(
  parameter logic [9:0] DEAD_LO = DEF_DEAD_LO,
  parameter logic [9:0] DEAD_HI = DEF_DEAD_HI,
  parameter logic [9:0] HYST    = DEF_HYST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       strobe_i,
  input  logic       clear_i,
  input  logic [9:0] pos_i,
  output zone_t      zone_d_o
);
  zone_t zone_q, zone_d;
  logic pos_in, neg_in, pos_out, neg_out;
  assign pos_in  = pos_i > DEAD_HI;
  assign neg_in  = pos_i < DEAD_LO;
  assign pos_out = pos_i < DEAD_HI - HYST;
  assign neg_out = pos_i > DEAD_LO + HYST;
  // A strong opposite deflection switches zones directly; the band between keeps the current zone.
  always_comb
    zone_d = pos_in ? Z_POS :
             neg_in ? Z_NEG :
             (zone_q == Z_POS && !pos_out) ? Z_POS :
             (zone_q == Z_NEG && !neg_out) ? Z_NEG : Z_NONE;
  always_ff @(posedge clk)
    if (rst || clear_i) zone_q <= Z_NONE;
    else if (strobe_i) zone_q <= zone_d;
  assign zone_d_o = zone_d;
endmodule

// File: rtl/jstk_adjust.sv
// jstk_adjust: turns PmodJSTK frames into stopwatch inc/dec/select/button pulses with link watchdog.
module jstk_adjust
  import jstk_pkg::*;
#(
  parameter logic [9:0] DEAD_LO      = DEF_DEAD_LO,
  parameter logic [9:0] DEAD_HI      = DEF_DEAD_HI,
  parameter logic [9:0] HYST         = DEF_HYST,
  parameter int         REPEAT_DELAY = 3,
  parameter int         REPEAT_RATE  = 1,
  parameter int         STALE_CYCLES = 40_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_valid,
  input  logic [39:0] jstk_data,
  output logic        inc,
  output logic        dec,
  output logic        sel,
  output logic [2:0]  btn_rise,
  output logic        stale
);
  localparam logic [25:0] WD_MAX = 26'(STALE_CYCLES);
  localparam logic [3:0]  DLY    = 4'(REPEAT_DELAY);
  localparam logic [3:0]  RATE   = 4'(REPEAT_RATE);
  zone_t yz, xz;
  logic [1:0] st_q, st_d;
  logic [3:0] cnt_q, cnt_d, cnt_m1;
  logic dir_q, dir_d, pulse, clear;
  logic inc_q, inc_d, dec_q, dec_d, sel_q, sel_d;
  logic [2:0] btn_q, btn_d, rise_q, rise_d;
  logic [25:0] wd_q, wd_d;
  assign stale = wd_q == WD_MAX;
  assign clear = stale && !frame_valid;
  jstk_axis_zone #(.DEAD_LO(DEAD_LO), .DEAD_HI(DEAD_HI), .HYST(HYST)) u_y (
    .clk(clk), .rst(rst), .strobe_i(frame_valid), .clear_i(clear),
    .pos_i(get_y(jstk_data)), .zone_d_o(yz)
  );
  jstk_axis_zone #(.DEAD_LO(DEAD_LO), .DEAD_HI(DEAD_HI), .HYST(HYST)) u_x (
    .clk(clk), .rst(rst), .strobe_i(frame_valid), .clear_i(clear),
    .pos_i(get_x(jstk_data)), .zone_d_o(xz)
  );
  assign cnt_m1 = cnt_q - 4'd1;
  // dir_q remembers the direction of the last pulse so a reversal is seen as a fresh press.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    dir_d = dir_q;
    pulse = 1'b0;
    if (clear) begin
      st_d  = ST_IDLE;
      cnt_d = 4'd0;
    end else if (frame_valid) begin
      if (yz == Z_NONE) st_d = ST_IDLE;
      else if (st_q == ST_IDLE || (yz == Z_POS) != dir_q) begin
        pulse = 1'b1;
        dir_d = yz == Z_POS;
        cnt_d = DLY;
        st_d  = ST_HOLD;
      end else begin
        cnt_d = cnt_m1;
        if (cnt_m1 == 4'd0) begin
          pulse = 1'b1;
          cnt_d = RATE;
          st_d  = ST_REPEAT;
        end
      end
    end
  end
  assign inc_d  = pulse && dir_d;
  assign dec_d  = pulse && !dir_d;
  assign sel_d  = !frame_valid ? sel_q : xz == Z_POS ? 1'b1 : xz == Z_NEG ? 1'b0 : sel_q;
  assign btn_d  = frame_valid ? jstk_data[BTN_W-1:0] : btn_q;
  assign rise_d = frame_valid ? jstk_data[BTN_W-1:0] & ~btn_q : 3'd0;
  assign wd_d   = frame_valid ? 26'd0 : stale ? wd_q : wd_q + 26'd1;
  always_ff @(posedge clk)
    if (rst) begin
      st_q   <= ST_IDLE;
      cnt_q  <= 4'd0;
      dir_q  <= 1'b0;
      inc_q  <= 1'b0;
      dec_q  <= 1'b0;
      sel_q  <= 1'b0;
      btn_q  <= 3'd0;
      rise_q <= 3'd0;
      wd_q   <= WD_MAX;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      inc_q  <= inc_d;
      dec_q  <= dec_d;
      sel_q  <= sel_d;
      btn_q  <= btn_d;
      rise_q <= rise_d;
      wd_q   <= wd_d;
    end
  assign inc      = inc_q;
  assign dec      = dec_q;
  assign sel      = sel_q;
  assign btn_rise = rise_q;
endmodule

// File: tb/tb_jstk_adjust.sv
// tb_jstk_adjust: directed frames with hand-computed responses checked by a scoreboard monitor.
module tb_jstk_adjust;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_valid = 1'b0;
  logic [39:0] jstk_data = 40'd0;
  logic inc, dec, sel, stale;
  logic [2:0] btn_rise;
  logic fv_last = 1'b0;
  logic [6:0] exp_q[$];
  logic [6:0] e, got;
  int total = 0;
  int passed = 0;

  jstk_adjust #(.REPEAT_DELAY(3), .REPEAT_RATE(1), .STALE_CYCLES(100)) dut (
    .clk(clk), .rst(rst), .frame_valid(frame_valid), .jstk_data(jstk_data),
    .inc(inc), .dec(dec), .sel(sel), .btn_rise(btn_rise), .stale(stale)
  );

  always #5 clk = ~clk;

  always @(posedge clk) fv_last <= frame_valid & ~rst;

  // Frame responses are popped one cycle after the strobe; other cycles must stay pulse-free.
  always @(negedge clk) begin
    got = {inc, dec, sel, btn_rise, stale};
    if (fv_last) begin
      total++;
      if (exp_q.size() == 0) $display("FAIL frame_resp: got %b, required nothing queued", got);
      else begin
        e = exp_q.pop_front();
        if (got !== e) $display("FAIL frame_resp {inc,dec,sel,rise,stale}: got %b required %b", got, e);
        else passed++;
      end
    end else if (!rst) begin
      total++;
      if ({inc, dec, btn_rise} !== 5'd0) $display("FAIL idle_pulse {inc,dec,rise}: got %b required 00000", {inc, dec, btn_rise});
      else passed++;
    end
  end

  task automatic chk(input string name, input logic [6:0] g, input logic [6:0] x);
    total++;
    if (g !== x) $display("FAIL %s: got %b required %b", name, g, x);
    else passed++;
  endtask

  task automatic frame(input logic [9:0] x, input logic [9:0] y, input logic [2:0] b,
                       input logic ei, input logic ed, input logic es, input logic [2:0] er);
    @(negedge clk);
    jstk_data = {x[7:0], 6'd0, x[9:8], y[7:0], 6'd0, y[9:8], 5'd0, b};
    frame_valid = 1'b1;
    exp_q.push_back({ei, ed, es, er, 1'b0});
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (19) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", {inc, dec, sel, btn_rise, stale}, 7'b0000001);
    // Hold up: first pulse, then delay of 3 frames, then every frame.
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 900, 0, 0, 0, 0, 0);
    frame(512, 900, 0, 0, 0, 0, 0);
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // Hysteresis band keeps UP; third frame is HOLD countdown, not a fresh press.
    frame(512, 650, 0, 1, 0, 0, 0);
    frame(512, 620, 0, 0, 0, 0, 0);
    frame(512, 650, 0, 0, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // Reversal restarts the delay in the new direction.
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 100, 0, 0, 1, 0, 0);
    frame(512, 100, 0, 0, 0, 0, 0);
    frame(512, 100, 0, 0, 0, 0, 0);
    frame(512, 100, 0, 0, 1, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // Exact thresholds are not deflections.
    frame(512, 640, 0, 0, 0, 0, 0);
    frame(512, 384, 0, 0, 0, 0, 0);
    frame(512, 641, 0, 1, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    frame(512, 383, 0, 0, 1, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // DN hysteresis: 400 stays in band, 512 releases, then a fresh dec.
    frame(512, 100, 0, 0, 1, 0, 0);
    frame(512, 400, 0, 0, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    frame(512, 100, 0, 0, 1, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // X select.
    frame(1000, 512, 0, 0, 0, 1, 0);
    frame(512, 512, 0, 0, 0, 1, 0);
    frame(10, 512, 0, 0, 0, 0, 0);
    frame(512, 512, 0, 0, 0, 0, 0);
    // Button rising edges.
    frame(512, 512, 3'b000, 0, 0, 0, 3'b000);
    frame(512, 512, 3'b001, 0, 0, 0, 3'b001);
    frame(512, 512, 3'b001, 0, 0, 0, 3'b000);
    frame(512, 512, 3'b011, 0, 0, 0, 3'b010);
    frame(512, 512, 3'b100, 0, 0, 0, 3'b100);
    frame(512, 512, 3'b000, 0, 0, 0, 3'b000);
    // Stale link drops the held deflection; the next frame is a fresh press.
    frame(512, 900, 0, 1, 0, 0, 0);
    repeat (30) @(negedge clk);
    chk("stale_before_sat", {6'd0, stale}, 7'd0);
    repeat (60) @(negedge clk);
    chk("stale_after_sat", {6'd0, stale}, 7'd1);
    frame(512, 900, 0, 1, 0, 0, 0);
    frame(512, 900, 0, 0, 0, 0, 0);
    // Reset mid-HOLD coinciding with a frame: frame discarded, FSM back to IDLE.
    @(negedge clk);
    rst = 1'b1;
    frame_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    frame_valid = 1'b0;
    chk("reset_mid_hold", {inc, dec, sel, btn_rise, stale}, 7'b0000001);
    frame(1000, 900, 0, 1, 0, 1, 0);
    frame(512, 512, 0, 0, 0, 1, 0);
    repeat (5) @(negedge clk);
    total++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", exp_q.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
